// File: rtl/spi_sensor_responder.sv
// SPI mode-3 sensor-style register responder: 7-bit address, R/W command byte,
// burst auto-increment, read-only identity byte, and a local register load port.
module spi_sensor_responder #(
    parameter logic [7:0] WHO_AM_I = 8'h68,
    parameter int         NREGS    = 16
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       CS_N,
    input  logic       SCK,
    input  logic       SDI,
    output logic       SDO,
    input  logic       LOAD_EN,
    input  logic [6:0] LOAD_ADDR,
    input  logic [7:0] LOAD_DATA,
    output logic       WR_VALID,
    output logic [6:0] WR_ADDR,
    output logic [7:0] WR_DATA
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cs_sync_q, sck_sync_q, sdi_sync_q;
    logic        cs_prev_q, sck_prev_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shin_q, shin_d;
    logic [7:0]  shout_q, shout_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic        sdo_q, sdo_d;
    logic        wr_valid_q;
    logic [6:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [7:0]  regs_q [NREGS];

    logic        cs_s, sck_s, sdi_s;
    logic        sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;
    logic [7:0]  byte_s;
    logic [6:0]  rd_addr_s;
    logic [7:0]  rd_data_s;
    logic        commit_s;

    function automatic logic is_writable(input logic [6:0] a);
        return (a != 7'h0F) && (int'(a) < NREGS);
    endfunction

    assign cs_s       = cs_sync_q[1];
    assign sck_s      = sck_sync_q[1];
    assign sdi_s      = sdi_sync_q[1];
    assign sck_rise_s = sck_s & ~sck_prev_q;
    assign sck_fall_s = ~sck_s & sck_prev_q;
    assign cs_fall_s  = ~cs_s & cs_prev_q;
    assign cs_rise_s  = cs_s & ~cs_prev_q;
    assign byte_s     = {shin_q, sdi_s};
    assign rd_addr_s  = (state_q == ADDR) ? byte_s[6:0] : (addr_q + 7'd1);

    // Synchronizers; CS resets "low" so a transfer already in progress at reset release is not joined mid-way
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cs_sync_q  <= 2'b00;
            sck_sync_q <= 2'b11;
            sdi_sync_q <= 2'b00;
            cs_prev_q  <= 1'b0;
            sck_prev_q <= 1'b1;
        end else begin
            cs_sync_q  <= {cs_sync_q[0], CS_N};
            sck_sync_q <= {sck_sync_q[0], SCK};
            sdi_sync_q <= {sdi_sync_q[0], SDI};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
        end
    end

    // Read-data mux for the byte about to be loaded into the shift-out register
    always_comb begin
        rd_data_s = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            rd_data_s = (rd_addr_s == 7'(i)) ? regs_q[i] : rd_data_s;
        end
        if (rd_addr_s == 7'h0F) begin
            rd_data_s = WHO_AM_I;
        end else begin
            rd_data_s = rd_data_s;
        end
    end

    // Transfer FSM next-state and datapath
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shin_d    = shin_q;
        shout_d   = shout_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        sdo_d     = sdo_q;
        commit_s  = 1'b0;
        case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                if (cs_fall_s) begin
                    state_d   = ADDR;
                    bit_cnt_d = 3'd0;
                    shin_d    = 7'd0;
                    shout_d   = 8'h00;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                sdo_d = 1'b0;
                if (sck_rise_s) begin
                    shin_d    = byte_s[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = DATA;
                        rw_d    = byte_s[7];
                        addr_d  = byte_s[6:0];
                        shout_d = byte_s[7] ? rd_data_s : 8'h00;
                    end else begin
                        state_d = ADDR;
                    end
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                if (sck_fall_s) begin
                    sdo_d   = shout_q[7];
                    shout_d = {shout_q[6:0], 1'b0};
                end else if (sck_rise_s) begin
                    shin_d    = byte_s[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d   = addr_q + 7'd1;
                        shout_d  = rw_q ? rd_data_s : 8'h00;
                        commit_s = ~rw_q & is_writable(addr_q);
                    end else begin
                        addr_d = addr_q;
                    end
                end else begin
                    sdo_d = sdo_q;
                end
            end
            default: begin
                state_d = IDLE;
                sdo_d   = 1'b0;
            end
        endcase
        // Deselect overrides everything; a byte in flight is dropped
        if (cs_rise_s) begin
            state_d   = IDLE;
            sdo_d     = 1'b0;
            bit_cnt_d = 3'd0;
            commit_s  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // FSM and shift-path state registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shin_q    <= 7'd0;
            shout_q   <= 8'h00;
            rw_q      <= 1'b0;
            addr_q    <= 7'd0;
            sdo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shin_q    <= shin_d;
            shout_q   <= shout_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            sdo_q     <= sdo_d;
        end
    end

    // Register file; the SPI commit is assigned last so it wins a same-cycle collision
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (LOAD_EN && is_writable(LOAD_ADDR) && (LOAD_ADDR == 7'(i))) begin
                    regs_q[i] <= LOAD_DATA;
                end
                if (commit_s && (addr_q == 7'(i))) begin
                    regs_q[i] <= byte_s;
                end
            end
        end
    end

    // Write notification outputs
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 8'h00;
        end else begin
            wr_valid_q <= commit_s;
            if (commit_s) begin
                wr_addr_q <= addr_q;
                wr_data_q <= byte_s;
            end
        end
    end

    assign SDO      = sdo_q;
    assign WR_VALID = wr_valid_q;
    assign WR_ADDR  = wr_addr_q;
    assign WR_DATA  = wr_data_q;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed bench for spi_sensor_responder: a table of single-register SPI
// transactions plus hand-written burst, wrap, abort, collision and reset sequences.
module tb_spi_sensor_responder;

    localparam int HALF = 6;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       CS_N = 1'b1;
    logic       SCK = 1'b1;
    logic       SDI = 1'b0;
    logic       SDO;
    logic       LOAD_EN = 1'b0;
    logic [6:0] LOAD_ADDR = 7'd0;
    logic [7:0] LOAD_DATA = 8'h00;
    logic       WR_VALID;
    logic [6:0] WR_ADDR;
    logic [7:0] WR_DATA;

    int         n_vec = 0;
    int         n_fail = 0;
    int         wr_count = 0;
    logic [6:0] wr_addr_seen = 7'd0;
    logic [7:0] wr_data_seen = 8'h00;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] exp_rd;
        int         exp_wr;
    } vec_t;

    vec_t tbl [12];

    spi_sensor_responder #(.WHO_AM_I(8'h68), .NREGS(16)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .CS_N(CS_N), .SCK(SCK), .SDI(SDI),
        .SDO(SDO), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
        .WR_VALID(WR_VALID), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
    );

    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) begin
        if (WR_VALID) begin
            wr_count     = wr_count + 1;
            wr_addr_seen = WR_ADDR;
            wr_data_seen = WR_DATA;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cs_low();
        CS_N = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(HALF);
        CS_N = 1'b1;
        tick(2 * HALF);
    endtask

    // Shift nbits of tx MSB-first; SDO is sampled just before each rising edge
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, input logic collide,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            SCK = 1'b0;
            SDI = tx[7-k];
            tick(HALF);
            rx[7-k] = SDO;
            SCK = 1'b1;
            if (collide && (k == nbits - 1)) begin
                LOAD_EN   = 1'b1;
                LOAD_ADDR = 7'h07;
                LOAD_DATA = 8'h99;
                tick(3);
                LOAD_EN = 1'b0;
                tick(HALF - 3);
            end else begin
                tick(HALF);
            end
        end
    endtask

    task automatic load(input logic [6:0] a, input logic [7:0] d);
        LOAD_EN   = 1'b1;
        LOAD_ADDR = a;
        LOAD_DATA = d;
        tick(1);
        LOAD_EN = 1'b0;
        tick(1);
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] exp, input string nm);
        logic [7:0] rx;
        cs_low();
        spi_xfer({1'b1, a}, 8, 1'b0, rx);
        spi_xfer(8'h00, 8, 1'b0, rx);
        cs_high();
        chk(nm, 32'(rx), 32'(exp));
    endtask

    initial begin
        logic [7:0] rx_a, rx_d, rx_b;
        int         w0;

        tbl[0]  = '{8'h8F, 8'h00, 8'h68, 0};  // identity
        tbl[1]  = '{8'h03, 8'hA5, 8'h00, 1};  // write 3
        tbl[2]  = '{8'h83, 8'h00, 8'hA5, 0};  // read back 3
        tbl[3]  = '{8'h0F, 8'h55, 8'h00, 0};  // identity is read-only
        tbl[4]  = '{8'h8F, 8'h00, 8'h68, 0};
        tbl[5]  = '{8'h10, 8'h77, 8'h00, 0};  // first unimplemented address
        tbl[6]  = '{8'h90, 8'h00, 8'h00, 0};
        tbl[7]  = '{8'h7F, 8'h12, 8'h00, 0};  // top of address space
        tbl[8]  = '{8'h8A, 8'h00, 8'h00, 0};  // reset value
        tbl[9]  = '{8'h0A, 8'hC3, 8'h00, 1};
        tbl[10] = '{8'h8A, 8'h00, 8'hC3, 0};
        tbl[11] = '{8'h00, 8'hFF, 8'h00, 1};  // lowest address

        tick(3);
        chk("reset SDO", 32'(SDO), 32'd0);
        chk("reset WR_VALID", 32'(WR_VALID), 32'd0);
        chk("reset WR_ADDR", 32'(WR_ADDR), 32'd0);
        chk("reset WR_DATA", 32'(WR_DATA), 32'd0);
        RESET_N = 1'b1;
        tick(2 * HALF);

        for (int v = 0; v < 12; v++) begin
            w0 = wr_count;
            cs_low();
            spi_xfer(tbl[v].cmd, 8, 1'b0, rx_a);
            spi_xfer(tbl[v].data, 8, 1'b0, rx_d);
            cs_high();
            chk($sformatf("vec%0d addr-phase SDO", v), 32'(rx_a), 32'd0);
            chk($sformatf("vec%0d WR_VALID pulses", v), 32'(wr_count - w0), 32'(tbl[v].exp_wr));
            if (tbl[v].cmd[7]) begin
                chk($sformatf("vec%0d read data", v), 32'(rx_d), 32'(tbl[v].exp_rd));
            end else if (tbl[v].exp_wr == 1) begin
                chk($sformatf("vec%0d WR_ADDR", v), 32'(wr_addr_seen), 32'(tbl[v].cmd[6:0]));
                chk($sformatf("vec%0d WR_DATA", v), 32'(wr_data_seen), 32'(tbl[v].data));
            end
        end

        // Burst read of locally loaded registers
        load(7'h04, 8'h11);
        load(7'h05, 8'h22);
        load(7'h06, 8'h33);
        w0 = wr_count;
        cs_low();
        spi_xfer(8'h84, 8, 1'b0, rx_a);
        spi_xfer(8'h00, 8, 1'b0, rx_a);
        spi_xfer(8'h00, 8, 1'b0, rx_b);
        spi_xfer(8'h00, 8, 1'b0, rx_d);
        cs_high();
        chk("burst byte0", 32'(rx_a), 32'h11);
        chk("burst byte1", 32'(rx_b), 32'h22);
        chk("burst byte2", 32'(rx_d), 32'h33);
        chk("burst no WR_VALID", 32'(wr_count - w0), 32'd0);

        // Address wraps 0x7F -> 0x00
        cs_low();
        spi_xfer(8'hFF, 8, 1'b0, rx_a);
        spi_xfer(8'h00, 8, 1'b0, rx_a);
        spi_xfer(8'h00, 8, 1'b0, rx_b);
        cs_high();
        chk("wrap byte 0x7F", 32'(rx_a), 32'h00);
        chk("wrap byte 0x00", 32'(rx_b), 32'hFF);

        // Aborted write after 5 data bits
        load(7'h02, 8'h5A);
        w0 = wr_count;
        cs_low();
        spi_xfer(8'h02, 8, 1'b0, rx_a);
        spi_xfer(8'hC6, 5, 1'b0, rx_a);
        cs_high();
        chk("abort no WR_VALID", 32'(wr_count - w0), 32'd0);
        rd(7'h02, 8'h5A, "abort reg2 unchanged");

        // LOAD_EN and SPI commit to register 7 in the same cycle
        w0 = wr_count;
        cs_low();
        spi_xfer(8'h07, 8, 1'b0, rx_a);
        spi_xfer(8'h3C, 8, 1'b1, rx_a);
        cs_high();
        chk("collision WR_VALID", 32'(wr_count - w0), 32'd1);
        chk("collision WR_DATA", 32'(wr_data_seen), 32'h3C);
        rd(7'h07, 8'h3C, "collision SPI wins");
        rd(7'h0F, 8'h68, "identity after writes");

        // Reset during the data phase of an identity read
        cs_low();
        spi_xfer(8'h8F, 8, 1'b0, rx_a);
        SCK = 1'b0;
        tick(HALF);
        SCK = 1'b1;
        tick(HALF);
        SCK = 1'b0;
        tick(HALF);
        chk("pre-reset SDO bit6", 32'(SDO), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("reset mid-read SDO", 32'(SDO), 32'd0);
        tick(2);
        SCK  = 1'b1;
        CS_N = 1'b1;
        tick(2);
        RESET_N = 1'b1;
        tick(2 * HALF);
        rd(7'h03, 8'h00, "post-reset reg3");
        rd(7'h04, 8'h00, "post-reset reg4");
        rd(7'h07, 8'h00, "post-reset reg7");
        rd(7'h0F, 8'h68, "post-reset identity");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
